vx_issue_arbiter: RTL and testbench

//   Selects one instruction per cycle from NUM_WARPS per-warp instruction-buffer heads and

---
 rtl/vx_issue_arbiter.sv | 178 +++++++++++++++++
 tb/tb_vx_issue_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/vx_issue_arbiter.sv
// Issue arbiter: picks one instruction per cycle from the per-warp ibuffer heads
// and presents it, registered, to the demux. Warps are served round-robin. A warp
// is skipped, rather than stalling the others, when its target execution unit has
// no issue credit left. Credits are taken when the output register loads and are
// given back by credit_ret pulses from the units.
module vx_issue_arbiter #(
    parameter int NUM_WARPS = 4,
    parameter int EX_BITS   = 3,
    parameter int NUM_EX    = 6,
    parameter int CREDITS   = 2,
    parameter int DATAW     = 64,
    localparam int NW_BITS  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int CW       = $clog2(CREDITS + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_WARPS-1:0]         req_valid,
    input  logic [NUM_WARPS*EX_BITS-1:0] req_ex_type,
    input  logic [NUM_WARPS*DATAW-1:0]   req_data,
    output logic [NUM_WARPS-1:0]         req_ready,
    output logic                         out_valid,
    output logic [NW_BITS-1:0]           out_wid,
    output logic [EX_BITS-1:0]           out_ex_type,
    output logic [DATAW-1:0]             out_data,
    input  logic                         out_ready,
    input  logic [NUM_EX-1:0]            credit_ret,
    output logic [NUM_EX-1:0]            credit_avail
);

    // Unit 0 is the NOP slot and never holds credits, so its return bit is unused.
    logic unused_credit_ret0;
    assign unused_credit_ret0 = credit_ret[0];

    logic [CW-1:0]        credit [1:NUM_EX-1];
    logic [NUM_EX-1:0]    credit_nz;
    logic [EX_BITS-1:0]   warp_ex [NUM_WARPS];
    logic [NUM_WARPS-1:0] eligible;
    logic [NUM_WARPS-1:0] bad_ex_type;
    logic [NW_BITS-1:0]   rr_ptr;
    logic [NW_BITS-1:0]   winner;
    logic                 any_elig;
    logic                 load;
    logic                 issue;
    logic [EX_BITS-1:0]   win_ex;
    logic [DATAW-1:0]     win_data;
    logic [NUM_EX-1:1]    consume;
    logic                 credit_overflow;

    assign load  = ~out_valid | out_ready;
    assign issue = load & any_elig & ~reset;

    // Non-zero flag for each unit's credit counter. NOP is always available.
    always_comb begin
        credit_nz    = '0;
        credit_nz[0] = 1'b1;
        for (int k = 1; k < NUM_EX; k++) begin
            credit_nz[k] = (credit[k] != '0);
        end
    end

    assign credit_avail = credit_nz;

    // Split out each warp's unit field. Check whether it targets a unit that has
    // credit. A unit number beyond NUM_EX matches no slot, so that warp is never
    // eligible.
    always_comb begin
        logic has_credit;
        has_credit  = 1'b0;
        eligible    = '0;
        bad_ex_type = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            warp_ex[i] = req_ex_type[i*EX_BITS +: EX_BITS];
            has_credit = 1'b0;
            for (int k = 0; k < NUM_EX; k++) begin
                if (int'(warp_ex[i]) == k) begin
                    has_credit = credit_nz[k];
                end
            end
            eligible[i]    = req_valid[i] & has_credit;
            bad_ex_type[i] = req_valid[i] & (int'(warp_ex[i]) >= NUM_EX);
        end
    end

    // Round-robin scan. Start at rr_ptr and take the first eligible warp.
    always_comb begin
        int idx;
        idx      = 0;
        any_elig = 1'b0;
        winner   = '0;
        for (int off = 0; off < NUM_WARPS; off++) begin
            idx = int'(rr_ptr) + off;
            if (idx >= NUM_WARPS) begin
                idx = idx - NUM_WARPS;
            end
            if (!any_elig && eligible[idx]) begin
                any_elig = 1'b1;
                winner   = NW_BITS'(idx);
            end
        end
    end

    assign win_ex   = warp_ex[winner];
    assign win_data = req_data[int'(winner)*DATAW +: DATAW];

    // The winner's head is consumed in the same cycle that the output register loads it.
    always_comb begin
        req_ready = '0;
        if (issue) begin
            req_ready[winner] = 1'b1;
        end
    end

    // Find which unit, if any, the instruction issued this cycle takes a credit from.
    always_comb begin
        consume         = '0;
        credit_overflow = 1'b0;
        for (int k = 1; k < NUM_EX; k++) begin
            consume[k] = issue & (int'(win_ex) == k);
            if (credit_ret[k] && !consume[k] && credit[k] == CW'(CREDITS)) begin
                credit_overflow = 1'b1;
            end
        end
    end

    // Credit counters. A return and a consume in the same cycle cancel out. A surplus return saturates.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k < NUM_EX; k++) begin
                credit[k] <= CW'(CREDITS);
            end
        end else begin
            for (int k = 1; k < NUM_EX; k++) begin
                case ({credit_ret[k], consume[k]})
                    2'b10: begin
                        if (credit[k] != CW'(CREDITS)) begin
                            credit[k] <= credit[k] + CW'(1);
                        end
                    end
                    2'b01:   credit[k] <= credit[k] - CW'(1);
                    default: credit[k] <= credit[k];
                endcase
            end
        end
    end

    // Advance the round-robin pointer past the warp that was just served.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (issue) begin
            rr_ptr <= (winner == NW_BITS'(NUM_WARPS - 1)) ? '0 : winner + NW_BITS'(1);
        end
    end

    // Output register. It loads when empty or when the demux drains it, and holds otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_wid     <= '0;
            out_ex_type <= '0;
            out_data    <= '0;
        end else if (load) begin
            if (any_elig) begin
                out_valid   <= 1'b1;
                out_wid     <= winner;
                out_ex_type <= win_ex;
                out_data    <= win_data;
            end else begin
                out_valid   <= 1'b0;
            end
        end
    end

    // Protocol checks: no out-of-range unit from the ibuffers, no surplus credit return.
    assert property (@(posedge clk) disable iff (reset) bad_ex_type == '0);
    assert property (@(posedge clk) disable iff (reset) !credit_overflow);

endmodule

// File: tb/tb_vx_issue_arbiter.sv
// Bench for vx_issue_arbiter. A table of per-cycle stimulus carries the expected
// req_ready, out_valid and credit_avail values. A scoreboard queue holds the
// instruction expected at the output. An entry is pushed when a warp is granted
// and checked when the demux takes it.
module tb_vx_issue_arbiter;

    localparam int NUM_WARPS = 4;
    localparam int EX_BITS   = 3;
    localparam int NUM_EX    = 6;
    localparam int DATAW     = 64;
    localparam int NW_BITS   = 2;

    logic                         clk;
    logic                         reset;
    logic [NUM_WARPS-1:0]         req_valid;
    logic [NUM_WARPS*EX_BITS-1:0] req_ex_type;
    logic [NUM_WARPS*DATAW-1:0]   req_data;
    logic [NUM_WARPS-1:0]         req_ready;
    logic                         out_valid;
    logic [NW_BITS-1:0]           out_wid;
    logic [EX_BITS-1:0]           out_ex_type;
    logic [DATAW-1:0]             out_data;
    logic                         out_ready;
    logic [NUM_EX-1:0]            credit_ret;
    logic [NUM_EX-1:0]            credit_avail;

    vx_issue_arbiter #(
        .NUM_WARPS(NUM_WARPS), .EX_BITS(EX_BITS), .NUM_EX(NUM_EX),
        .CREDITS(2), .DATAW(DATAW)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ex_type(req_ex_type), .req_data(req_data),
        .req_ready(req_ready),
        .out_valid(out_valid), .out_wid(out_wid), .out_ex_type(out_ex_type),
        .out_data(out_data), .out_ready(out_ready),
        .credit_ret(credit_ret), .credit_avail(credit_avail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [11:0] ex;
        logic        ordy;
        logic [5:0]  ret;
        logic        exp_ov;
        logic [3:0]  exp_rdy;
        logic [5:0]  exp_avail;
    } vec_t;

    typedef struct {
        logic [NW_BITS-1:0] wid;
        logic [EX_BITS-1:0] ex;
        logic [DATAW-1:0]   data;
    } item_t;

    vec_t  vecs[$];
    item_t sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    function automatic logic [11:0] ex4(int w0, int w1, int w2, int w3);
        return {3'(w3), 3'(w2), 3'(w1), 3'(w0)};
    endfunction

    function automatic logic [DATAW-1:0] data_of(int vi, int w);
        return {32'hC0DE_0000 | 32'(vi), 32'h5A00_0000 | 32'(w)};
    endfunction

    function automatic vec_t mk(logic rst, logic [3:0] valid, logic [11:0] ex, logic ordy,
                                logic [5:0] ret, logic exp_ov, logic [3:0] exp_rdy,
                                logic [5:0] exp_avail);
        vec_t v;
        v.rst = rst; v.valid = valid; v.ex = ex; v.ordy = ordy; v.ret = ret;
        v.exp_ov = exp_ov; v.exp_rdy = exp_rdy; v.exp_avail = exp_avail;
        return v;
    endfunction

    task automatic check(string name, int vi, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec=%0d got=%h expected=%h", name, vi, act, exp);
        end
    endtask

    initial begin
        item_t it;
        vec_t  v;
        int    wid;

        // reset, all warps ex 1, credit 1 returned each cycle
        vecs.push_back(mk(1, 4'hF, ex4(1,1,1,1), 1, 6'h02, 0, 4'h0, 6'h3F));
        vecs.push_back(mk(0, 4'hF, ex4(1,1,1,1), 1, 6'h02, 0, 4'h1, 6'h3F));
        vecs.push_back(mk(0, 4'hF, ex4(1,1,1,1), 1, 6'h02, 1, 4'h2, 6'h3F));
        vecs.push_back(mk(0, 4'hF, ex4(1,1,1,1), 1, 6'h02, 1, 4'h4, 6'h3F));
        vecs.push_back(mk(0, 4'hF, ex4(1,1,1,1), 1, 6'h02, 1, 4'h8, 6'h3F));
        vecs.push_back(mk(0, 4'hF, ex4(1,1,1,1), 1, 6'h02, 1, 4'h1, 6'h3F));
        // fairness: w0,w2 with rr_ptr=1
        vecs.push_back(mk(0, 4'h5, ex4(1,1,1,1), 1, 6'h02, 1, 4'h4, 6'h3F));
        vecs.push_back(mk(0, 4'h5, ex4(1,1,1,1), 1, 6'h02, 1, 4'h1, 6'h3F));
        vecs.push_back(mk(0, 4'h5, ex4(1,1,1,1), 1, 6'h02, 1, 4'h4, 6'h3F));
        vecs.push_back(mk(0, 4'h5, ex4(1,1,1,1), 1, 6'h02, 1, 4'h1, 6'h3F));
        // credit exhaustion on unit 2, bypass by w2, return re-enables
        vecs.push_back(mk(0, 4'h3, ex4(2,2,0,0), 1, 6'h00, 1, 4'h2, 6'h3F));
        vecs.push_back(mk(0, 4'h3, ex4(2,2,0,0), 1, 6'h00, 1, 4'h1, 6'h3F));
        vecs.push_back(mk(0, 4'h7, ex4(2,2,1,0), 1, 6'h00, 1, 4'h4, 6'h3B));
        vecs.push_back(mk(0, 4'h3, ex4(2,2,0,0), 1, 6'h04, 1, 4'h0, 6'h3B));
        vecs.push_back(mk(0, 4'h3, ex4(2,2,0,0), 1, 6'h00, 0, 4'h1, 6'h3F));
        // back-pressure for 3 cycles
        vecs.push_back(mk(0, 4'hC, ex4(0,0,1,1), 0, 6'h00, 1, 4'h0, 6'h3B));
        vecs.push_back(mk(0, 4'hC, ex4(0,0,1,1), 0, 6'h00, 1, 4'h0, 6'h3B));
        vecs.push_back(mk(0, 4'hC, ex4(0,0,1,1), 0, 6'h00, 1, 4'h0, 6'h3B));
        vecs.push_back(mk(0, 4'hC, ex4(0,0,1,1), 1, 6'h00, 1, 4'h4, 6'h3B));
        // unit 1 at 0: return makes it eligible next cycle; return+issue at 1 holds 1
        vecs.push_back(mk(0, 4'h8, ex4(0,0,0,1), 1, 6'h02, 1, 4'h0, 6'h39));
        vecs.push_back(mk(0, 4'h8, ex4(0,0,0,1), 1, 6'h02, 0, 4'h8, 6'h3B));
        vecs.push_back(mk(0, 4'h0, ex4(0,0,0,0), 1, 6'h00, 1, 4'h0, 6'h3B));
        // drain every unit to zero credits
        vecs.push_back(mk(0, 4'hF, ex4(3,3,4,4), 1, 6'h00, 0, 4'h1, 6'h3B));
        vecs.push_back(mk(0, 4'hF, ex4(3,3,4,4), 1, 6'h00, 1, 4'h2, 6'h3B));
        vecs.push_back(mk(0, 4'hF, ex4(3,3,4,4), 1, 6'h00, 1, 4'h4, 6'h33));
        vecs.push_back(mk(0, 4'hF, ex4(3,3,4,4), 1, 6'h00, 1, 4'h8, 6'h33));
        vecs.push_back(mk(0, 4'h3, ex4(5,5,0,0), 1, 6'h00, 1, 4'h1, 6'h23));
        vecs.push_back(mk(0, 4'h3, ex4(5,5,0,0), 1, 6'h00, 1, 4'h2, 6'h23));
        vecs.push_back(mk(0, 4'h1, ex4(1,0,0,0), 1, 6'h00, 1, 4'h1, 6'h03));
        // NOPs still issue with no credits anywhere, then reset mid-stream
        vecs.push_back(mk(0, 4'hF, ex4(0,0,0,0), 1, 6'h00, 1, 4'h2, 6'h01));
        vecs.push_back(mk(0, 4'hF, ex4(0,0,0,0), 1, 6'h00, 1, 4'h4, 6'h01));
        vecs.push_back(mk(1, 4'hF, ex4(0,0,0,0), 1, 6'h00, 1, 4'h0, 6'h01));
        vecs.push_back(mk(0, 4'h0, ex4(0,0,0,0), 1, 6'h00, 0, 4'h0, 6'h3F));

        reset       = 1'b1;
        req_valid   = '0;
        req_ex_type = '0;
        req_data    = '0;
        out_ready   = 1'b0;
        credit_ret  = '0;
        repeat (2) @(posedge clk);

        for (int vi = 0; vi < vecs.size(); vi++) begin
            v = vecs[vi];
            @(negedge clk);
            reset       = v.rst;
            req_valid   = v.valid;
            req_ex_type = v.ex;
            out_ready   = v.ordy;
            credit_ret  = v.ret;
            for (int w = 0; w < NUM_WARPS; w++) begin
                req_data[w*DATAW +: DATAW] = data_of(vi, w);
            end
            #1;
            check("out_valid", vi, 64'(out_valid), 64'(v.exp_ov));
            check("req_ready", vi, 64'(req_ready), 64'(v.exp_rdy));
            check("credit_avail", vi, 64'(credit_avail), 64'(v.exp_avail));

            if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("sb_nonempty", vi, 64'(0), 64'(1));
                end else begin
                    it = v.ordy ? sb.pop_front() : sb[0];
                    check(v.ordy ? "out_wid" : "stall_wid", vi, 64'(out_wid), 64'(it.wid));
                    check(v.ordy ? "out_ex_type" : "stall_ex_type", vi,
                          64'(out_ex_type), 64'(it.ex));
                    check(v.ordy ? "out_data" : "stall_data", vi, out_data, it.data);
                end
            end

            if (!v.rst && v.exp_rdy != 4'h0) begin
                wid = 0;
                for (int w = 0; w < NUM_WARPS; w++) begin
                    if (v.exp_rdy[w]) wid = w;
                end
                it.wid  = NW_BITS'(wid);
                it.ex   = v.ex[wid*EX_BITS +: EX_BITS];
                it.data = data_of(vi, wid);
                sb.push_back(it);
            end
        end

        // After the mid-stream reset the output register must read back at its reset values.
        @(negedge clk);
        req_valid  = '0;
        credit_ret = '0;
        #1;
        check("rst_out_valid", -1, 64'(out_valid), 64'(0));
        check("rst_out_wid", -1, 64'(out_wid), 64'(0));
        check("rst_out_ex_type", -1, 64'(out_ex_type), 64'(0));
        check("rst_out_data", -1, out_data, 64'(0));
        check("rst_credit_avail", -1, 64'(credit_avail), 64'h3F);
        check("sb_drained", -1, 64'(sb.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
